// File: rtl/cl_adder_pkg.sv
// Shared definitions for the adder FIFO master: default parameter values,
// TX/RX state encodings and the nibble-sum helper used to predict results.
package cl_adder_pkg;

    localparam int DEFAULT_DATA_WIDTH      = 32;
    localparam int DEFAULT_MAX_OUTSTANDING = 4;
    localparam int DEFAULT_TIMEOUT_CYCLES  = 1024;

    typedef enum logic {
        TX_IDLE  = 1'b0,
        TX_WRITE = 1'b1
    } tx_state_e;

    typedef enum logic {
        RX_IDLE = 1'b0,
        RX_HOLD = 1'b1
    } rx_state_e;

    // The adder answers every word with the sum of its two low nibbles.
    function automatic logic [4:0] nibble_sum(input logic [7:0] b);
        return {1'b0, b[3:0]} + {1'b0, b[7:4]};
    endfunction

endpackage

// File: rtl/cl_adder_fifo_master_if.sv
// Bus bundle between the adder FIFO master and its environment: host command
// port, adder input FIFO write side, adder output FIFO read side (FWFT) and
// host result port.
//
// Handshakes: cmd and res transfer exactly on a rising clock edge where valid
// and ready are both high; valid, once raised, holds its data stable until
// that edge. req_wr writes req_dout only when req_full is low; rsp_rd pops
// rsp_din (already presented by the FWFT FIFO) only when rsp_empty is low.
interface cl_adder_fifo_master_if
    import cl_adder_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [DATA_WIDTH-1:0] cmd_data;

    logic                  req_full;
    logic                  req_wr;
    logic [DATA_WIDTH-1:0] req_dout;

    logic                  rsp_empty;
    logic                  rsp_rd;
    logic [DATA_WIDTH-1:0] rsp_din;

    logic                  res_valid;
    logic                  res_ready;
    logic [DATA_WIDTH-1:0] res_data;

    modport master (
        input  cmd_valid, cmd_data,
        output cmd_ready,
        input  req_full,
        output req_wr, req_dout,
        input  rsp_empty, rsp_din,
        output rsp_rd,
        output res_valid, res_data,
        input  res_ready
    );

    modport slave (
        output cmd_valid, cmd_data,
        input  cmd_ready,
        output req_full,
        input  req_wr, req_dout,
        output rsp_empty, rsp_din,
        input  rsp_rd,
        input  res_valid, res_data,
        output res_ready
    );

endinterface

// File: rtl/cl_adder_expect_fifo.sv
// Small synchronous FIFO holding predicted adder results in send order.
// Head is visible combinationally; a pop and a push may share a cycle even
// when full.
module cl_adder_expect_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full || do_pop);
    assign head_o  = mem_q[rd_ptr_q];

    // Pointer and occupancy next-state.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = bump(wr_ptr_q);
        if (do_pop)  rd_ptr_d = bump(rd_ptr_q);
        if (do_push && !do_pop)      count_d = count_q + CW'(1);
        else if (!do_push && do_pop) count_d = count_q - CW'(1);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; contents are don't-care until written.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/cl_adder_fifo_master.sv
// Adder FIFO master: takes host operand words, writes them one at a time into
// the adder input FIFO, pops answers from the adder output FIFO and hands them
// back to the host. Tracks in-flight requests, flags a stuck adder (sticky
// timeout_err) and, when built with ADDER_RESULT_CHECK_EN, checks every answer
// against the predicted nibble sum (sticky mismatch_err).
module cl_adder_fifo_master
    import cl_adder_pkg::*;
#(
    parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
    parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
    parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                          clock,
    input  logic                          reset,
    cl_adder_fifo_master_if.master        bus,
    output logic [3:0]                    outstanding,
    output logic                          timeout_err,
    output logic                          mismatch_err,
    output tx_state_e                     tx_state_o,
    output rx_state_e                     rx_state_o
);

    localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);
    localparam int         TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

    tx_state_e             tx_state_q, tx_state_d;
    rx_state_e             rx_state_q, rx_state_d;
    logic [DATA_WIDTH-1:0] tx_word_q, tx_word_d;
    logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
    logic [3:0]            out_q, out_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic                  timeout_q, timeout_d;
    logic                  mismatch_q, mismatch_d;
    logic                  cmd_ready;
    logic                  req_wr;
    logic                  rsp_rd;
    logic                  res_valid;
    logic                  check_fail;

    // TX: accept one word into the holding register, then write it out once
    // the adder FIFO has room.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_word_d  = tx_word_q;
        cmd_ready  = 1'b0;
        req_wr     = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                cmd_ready = !reset && (out_q < MAX_OUT);
                if (bus.cmd_valid && cmd_ready) begin
                    tx_word_d  = bus.cmd_data;
                    tx_state_d = TX_WRITE;
                end
            end
            TX_WRITE: begin
                req_wr = !reset && !bus.req_full;
                if (req_wr) tx_state_d = TX_IDLE;
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // RX: pop one answer, hold it on the result port until the host takes it.
    always_comb begin
        rx_state_d = rx_state_q;
        res_data_d = res_data_q;
        rsp_rd     = 1'b0;
        res_valid  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rsp_rd = !reset && !bus.rsp_empty;
                if (rsp_rd) begin
                    res_data_d = bus.rsp_din;
                    rx_state_d = RX_HOLD;
                end
            end
            RX_HOLD: begin
                res_valid = !reset;
                if (bus.res_ready) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

`ifdef ADDER_RESULT_CHECK_EN
    logic [DATA_WIDTH-1:0] exp_word;
    logic [DATA_WIDTH-1:0] exp_head;
    logic                  exp_empty;

    assign exp_word = DATA_WIDTH'(nibble_sum(tx_word_q[7:0]));

    cl_adder_expect_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (MAX_OUTSTANDING)
    ) u_expect_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (req_wr),
        .push_data_i (exp_word),
        .pop_i       (rsp_rd),
        .head_o      (exp_head),
        .empty_o     (exp_empty)
    );

    // An answer with nothing expected counts as a mismatch too.
    assign check_fail = rsp_rd && (exp_empty || (exp_head != bus.rsp_din));
`else
    assign check_fail = 1'b0;
`endif

    // In-flight count, response watchdog and sticky error flags.
    always_comb begin
        out_d      = out_q;
        timer_d    = timer_q;
        timeout_d  = timeout_q;
        mismatch_d = mismatch_q | check_fail;
        if (req_wr && !rsp_rd) begin
            if (out_q < MAX_OUT) out_d = out_q + 4'd1;
        end else if (rsp_rd && !req_wr) begin
            if (out_q != 4'd0) out_d = out_q - 4'd1;
        end
        if ((out_q == 4'd0) || rsp_rd) begin
            timer_d = '0;
        end else if (timer_q != TMAX) begin
            timer_d = timer_q + TW'(1);
        end
        if (timer_d == TMAX) timeout_d = 1'b1;
    end

    // All state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            rx_state_q <= RX_IDLE;
            tx_word_q  <= '0;
            res_data_q <= '0;
            out_q      <= '0;
            timer_q    <= '0;
            timeout_q  <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            rx_state_q <= rx_state_d;
            tx_word_q  <= tx_word_d;
            res_data_q <= res_data_d;
            out_q      <= out_d;
            timer_q    <= timer_d;
            timeout_q  <= timeout_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.req_wr    = req_wr;
    assign bus.req_dout  = tx_word_q;
    assign bus.rsp_rd    = rsp_rd;
    assign bus.res_valid = res_valid;
    assign bus.res_data  = res_data_q;
    assign outstanding   = out_q;
    assign timeout_err   = timeout_q;
    assign mismatch_err  = mismatch_q;
    assign tx_state_o    = tx_state_q;
    assign rx_state_o    = rx_state_q;

endmodule

// File: tb/tb_cl_adder_fifo_master.sv
// Directed bench for cl_adder_fifo_master (MAX_OUTSTANDING=4, TIMEOUT_CYCLES=16).
// Mismatch expectations follow whether ADDER_RESULT_CHECK_EN is defined.
module tb_cl_adder_fifo_master;
    import cl_adder_pkg::*;

    logic      clock;
    logic      reset;
    logic [3:0] outstanding;
    logic      timeout_err;
    logic      mismatch_err;
    tx_state_e tx_state;
    rx_state_e rx_state;

    int n_checks = 0;
    int n_errors = 0;
    int wr_count = 0;
    int rd_count = 0;
    int base_wr;
    int base_rd;
    logic exp_mm;

    cl_adder_fifo_master_if #(.DATA_WIDTH(32)) bus ();

    cl_adder_fifo_master #(
        .DATA_WIDTH      (32),
        .MAX_OUTSTANDING (4),
        .TIMEOUT_CYCLES  (16)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus),
        .outstanding  (outstanding),
        .timeout_err  (timeout_err),
        .mismatch_err (mismatch_err),
        .tx_state_o   (tx_state),
        .rx_state_o   (rx_state)
    );

    // Clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count FIFO strobes away from the active edge.
    always @(negedge clock) begin
        if (bus.req_wr) wr_count++;
        if (bus.rsp_rd) rd_count++;
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
`ifdef ADDER_RESULT_CHECK_EN
        exp_mm = 1'b1;
`else
        exp_mm = 1'b0;
`endif
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = '0;
        bus.req_full  = 1'b0;
        bus.rsp_empty = 1'b1;
        bus.rsp_din   = '0;
        bus.res_ready = 1'b0;

        // Reset state
        tick(); tick(); #1;
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 0);
        chk("rst_req_wr", 32'(bus.req_wr), 0);
        chk("rst_rsp_rd", 32'(bus.rsp_rd), 0);
        chk("rst_res_valid", 32'(bus.res_valid), 0);
        chk("rst_req_dout", bus.req_dout, 0);
        chk("rst_res_data", bus.res_data, 0);
        chk("rst_outstanding", 32'(outstanding), 0);
        chk("rst_timeout", 32'(timeout_err), 0);
        chk("rst_mismatch", 32'(mismatch_err), 0);
        reset = 1'b0;
        #1;
        chk("idle_cmd_ready", 32'(bus.cmd_ready), 1);

        // Single command, FIFO has room
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 32'h0000_0035;
        tick();
        bus.cmd_valid = 1'b0;
        #1;
        chk("w1_req_wr", 32'(bus.req_wr), 1);
        chk("w1_req_dout", bus.req_dout, 32'h35);
        chk("w1_out_before", 32'(outstanding), 0);
        chk("w1_cmd_ready_busy", 32'(bus.cmd_ready), 0);
        tick(); #1;
        chk("w1_req_wr_done", 32'(bus.req_wr), 0);
        chk("w1_out_after", 32'(outstanding), 1);
        chk("w1_wr_count", wr_count, 1);

        // Response held while host stalls; second word waits in the FIFO
        bus.rsp_din   = 32'h0000_0008;
        bus.rsp_empty = 1'b0;
        #1;
        chk("r1_rsp_rd", 32'(bus.rsp_rd), 1);
        tick();
        bus.rsp_din = 32'h0000_0099;
        #1;
        chk("r1_res_valid", 32'(bus.res_valid), 1);
        chk("r1_res_data", bus.res_data, 32'h8);
        chk("r1_out", 32'(outstanding), 0);
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            chk("r1_hold_valid", 32'(bus.res_valid), 1);
            chk("r1_hold_data", bus.res_data, 32'h8);
            chk("r1_hold_no_rd", 32'(bus.rsp_rd), 0);
        end
        chk("r1_rd_count", rd_count, 1);
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        #1;
        chk("r1_released", 32'(bus.res_valid), 0);
        chk("r2_orphan_rd", 32'(bus.rsp_rd), 1);
        tick();
        bus.rsp_empty = 1'b1;
        #1;
        chk("r2_res_data", bus.res_data, 32'h99);
        chk("r2_out_zero", 32'(outstanding), 0);
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        #1;
        chk("r2_released", 32'(bus.res_valid), 0);

        // Adder FIFO full for 5 cycles after accept
        bus.req_full  = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 32'h0000_00A5;
        tick();
        bus.cmd_valid = 1'b0;
        base_wr = wr_count;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("full_no_wr", 32'(bus.req_wr), 0);
            chk("full_hold_word", bus.req_dout, 32'hA5);
            tick();
        end
        bus.req_full = 1'b0;
        #1;
        chk("full_release_wr", 32'(bus.req_wr), 1);
        chk("full_release_word", bus.req_dout, 32'hA5);
        tick(); #1;
        chk("full_one_wr", wr_count, base_wr + 1);
        chk("full_out", 32'(outstanding), 1);

        // No answer: watchdog fires after 16 waiting cycles
        for (int i = 0; i < 15; i++) tick();
        #1;
        chk("to_not_yet", 32'(timeout_err), 0);
        tick(); #1;
        chk("to_fired", 32'(timeout_err), 1);

        // Fill to the in-flight limit
        for (int k = 0; k < 3; k++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_data  = 32'h40 + 32'(k);
            tick();
            bus.cmd_valid = 1'b0;
            tick(); #1;
            chk("fill_out", 32'(outstanding), 32'(k + 2));
        end
        chk("limit_cmd_ready", 32'(bus.cmd_ready), 0);
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 32'h77;
        tick(); #1;
        chk("limit_tx_idle", 32'(tx_state), 32'(TX_IDLE));
        tick(); #1;
        chk("limit_no_wr", 32'(bus.req_wr), 0);
        chk("limit_out", 32'(outstanding), 4);
        chk("to_sticky", 32'(timeout_err), 1);
        bus.cmd_valid = 1'b0;

        // One answer frees a slot
        bus.rsp_empty = 1'b0;
        bus.rsp_din   = 32'h11;
        bus.res_ready = 1'b1;
        #1;
        chk("drain_rd", 32'(bus.rsp_rd), 1);
        tick();
        bus.rsp_empty = 1'b1;
        #1;
        chk("drain_out", 32'(outstanding), 3);
        chk("drain_data", bus.res_data, 32'h11);
        tick(); #1;
        chk("drain_done", 32'(bus.res_valid), 0);

        // Write and read in the same cycle leave the count alone
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 32'h22;
        #1;
        chk("same_cmd_ready", 32'(bus.cmd_ready), 1);
        tick();
        bus.cmd_valid = 1'b0;
        bus.rsp_empty = 1'b0;
        bus.rsp_din   = 32'h33;
        #1;
        chk("same_wr", 32'(bus.req_wr), 1);
        chk("same_rd", 32'(bus.rsp_rd), 1);
        tick();
        bus.rsp_empty = 1'b1;
        #1;
        chk("same_out", 32'(outstanding), 3);
        tick();
        bus.res_ready = 1'b0;

        // Reset with a command stuck behind full and a result held
        bus.req_full  = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 32'h5A;
        bus.rsp_empty = 1'b0;
        bus.rsp_din   = 32'h44;
        tick();
        bus.cmd_valid = 1'b0;
        #1;
        chk("mid_tx_write", 32'(tx_state), 32'(TX_WRITE));
        chk("mid_rx_hold", 32'(rx_state), 32'(RX_HOLD));
        reset        = 1'b1;
        bus.req_full = 1'b0;
        base_wr = wr_count;
        base_rd = rd_count;
        #1;
        chk("mid_rst_no_wr", 32'(bus.req_wr), 0);
        chk("mid_rst_no_rd", 32'(bus.rsp_rd), 0);
        tick(); tick();
        bus.rsp_empty = 1'b1;
        reset = 1'b0;
        #1;
        chk("mid_tx_idle", 32'(tx_state), 32'(TX_IDLE));
        chk("mid_rx_idle", 32'(rx_state), 32'(RX_IDLE));
        chk("mid_res_valid", 32'(bus.res_valid), 0);
        chk("mid_out", 32'(outstanding), 0);
        chk("mid_timeout_clr", 32'(timeout_err), 0);
        chk("mid_req_dout", bus.req_dout, 0);
        chk("mid_res_data", bus.res_data, 0);
        tick(); #1;
        chk("mid_wr_count", wr_count, base_wr);
        chk("mid_rd_count", rd_count, base_rd);

        // Result check: 0xFF -> 0xF + 0xF = 0x1E
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 32'hFF;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        bus.rsp_din   = 32'h1E;
        bus.rsp_empty = 1'b0;
        bus.res_ready = 1'b1;
        tick();
        bus.rsp_empty = 1'b1;
        #1;
        chk("chk_good_data", bus.res_data, 32'h1E);
        chk("chk_good_flag", 32'(mismatch_err), 0);
        tick();
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 32'hFF;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        bus.rsp_din   = 32'h1F;
        bus.rsp_empty = 1'b0;
        tick();
        bus.rsp_empty = 1'b1;
        #1;
        chk("chk_bad_flag", 32'(mismatch_err), 32'(exp_mm));
        chk("chk_bad_data", bus.res_data, 32'h1F);
        tick(); tick(); #1;
        chk("chk_bad_sticky", 32'(mismatch_err), 32'(exp_mm));
        chk("chk_end_out", 32'(outstanding), 0);
        bus.res_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cl_adder_fifo_master.md
CL_ADDER_FIFO_MASTER -- requirements
Module: cl_adder_fifo_master

Interface
REQ-001 Parameter DATA_WIDTH, default 32, word width of every data path.
REQ-002 Parameter MAX_OUTSTANDING, default 4, maximum requests written but not yet answered (1..15).
REQ-003 Parameter TIMEOUT_CYCLES, default 1024, idle-response cycles before timeout error.
REQ-004 Port clock, input, 1, single clock for all logic.
REQ-005 Port reset, input, 1, synchronous, active-high.
REQ-006 Ports cmd_valid, cmd_ready, cmd_data: input, output, DATA_WIDTH; host operand word; valid/ready handshake.
REQ-007 Ports req_full, req_wr, req_dout: input, output, DATA_WIDTH; write side of the adder input FIFO.
REQ-008 Ports rsp_empty, rsp_rd, rsp_din: input, output, DATA_WIDTH; read side of the adder output FIFO, first-word-fall-through.
REQ-009 Ports res_valid, res_ready, res_data: output, input, DATA_WIDTH; result to host; valid/ready handshake.
REQ-010 Port outstanding, output, 4, current in-flight request count.
REQ-011 Port timeout_err, output, 1, sticky timeout flag.
REQ-012 Port mismatch_err, output, 1, sticky result-check flag.

Function
REQ-013 Transfer on cmd side SHALL occur on a cycle with cmd_valid and cmd_ready both high; same for res side.
REQ-014 cmd_ready SHALL be high only when the TX holding register is empty, outstanding < MAX_OUTSTANDING, and reset is low.
REQ-015 TX FSM states: TX_IDLE, TX_WRITE; accepted command moves TX_IDLE -> TX_WRITE and latches cmd_data.
REQ-016 In TX_WRITE with req_full low, req_wr SHALL pulse for exactly one cycle with req_dout = latched word, then return to TX_IDLE.
REQ-017 In TX_WRITE with req_full high, req_wr SHALL stay low and the word SHALL be held; no word is dropped or duplicated.
REQ-018 RX FSM states: RX_IDLE, RX_HOLD; in RX_IDLE with rsp_empty low, rsp_rd SHALL pulse one cycle, rsp_din SHALL be captured into res_data, and the FSM SHALL enter RX_HOLD with res_valid high next cycle.
REQ-019 In RX_HOLD res_valid and res_data SHALL be stable until res_ready; on transfer, return to RX_IDLE; rsp_rd SHALL never be asserted while rsp_empty is high.
REQ-020 outstanding SHALL increment on req_wr, decrement on rsp_rd, and stay unchanged when both occur in the same cycle; it SHALL never wrap below 0 or above MAX_OUTSTANDING.
REQ-021 A response popped while outstanding = 0 SHALL still be forwarded; outstanding stays 0.
REQ-022 Timeout counter SHALL count cycles with outstanding > 0 and no rsp_rd, clear on rsp_rd or outstanding = 0, and set timeout_err when it reaches TIMEOUT_CYCLES.
REQ-023 timeout_err and mismatch_err SHALL remain set until reset; neither flag blocks traffic.
REQ-024 Latency: cmd accept to req_wr = 1 cycle minimum; rsp_rd to res_valid = 1 cycle.

Reset
REQ-025 On reset: cmd_ready, req_wr, rsp_rd, res_valid, timeout_err, mismatch_err = 0; req_dout, res_data = 0; outstanding = 0; both FSMs idle; timeout counter = 0.
REQ-026 Reset mid-operation SHALL discard the held command and held result without issuing any further req_wr or rsp_rd.

Configuration
REQ-027 Macro ADDER_RESULT_CHECK_EN defined: each sent word pushes expected = zero-extended cmd_data[3:0] + cmd_data[7:4] into an expectation queue of depth MAX_OUTSTANDING; each popped response is compared to the head entry and mismatch_err is set on inequality or an empty queue.
REQ-028 Macro undefined: no queue is instantiated and mismatch_err is tied to 0.

Structure
REQ-029 Shared package cl_adder_pkg SHALL hold the TX and RX state encodings and the default parameter constants.
REQ-030 Expectation queue SHALL be sub-module cl_adder_expect_fifo, instantiated only under ADDER_RESULT_CHECK_EN.

Verification
REQ-031 cmd 0x00000035, req_full=0 -> req_wr one cycle later with req_dout 0x00000035; outstanding 0 -> 1.
REQ-032 req_full held high 5 cycles after accept -> req_wr low throughout, and exactly one req_wr with the same word once req_full drops.
REQ-033 rsp_din 0x00000008 with rsp_empty low, res_ready low 3 cycles -> single rsp_rd, res_data 0x00000008 stable until res_ready.
REQ-034 Issue 4 commands with no responses -> cmd_ready low at outstanding=4; same-cycle req_wr and rsp_rd -> count unchanged.
REQ-035 TIMEOUT_CYCLES=16, one request, no response -> timeout_err rises after 16 cycles and stays high until reset.
REQ-036 With ADDER_RESULT_CHECK_EN: send 0x000000FF, respond 0x0000001E -> mismatch_err stays 0; respond 0x0000001F -> mismatch_err = 1.
